// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
//   occ_t          : occupancy / state encoding of a skid stage (0..2 entries)
//   CTRL_*         : bit positions inside the control bundle, identical for
//                    every stage instance so bubbles mean the same everywhere
//   *_DATA_W       : default data-bundle widths of the classic stage boundaries
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_JTYPE    = 2;
  localparam int CTRL_MEMWRITE = 3;

  // PC + instruction
  localparam int IFID_DATA_W  = 64;
  // PC + two operands + immediate + dest address
  localparam int IDEX_DATA_W  = 133;
  // ALUOut + store data + ALUSelect + WriteAddress
  localparam int EXMEM_DATA_W = 75;
  // DataMemOut + ALUOut + ALUSelect + WriteAddress
  localparam int MEMWB_DATA_W = 75;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: valid bit, control bundle, data bundle.
// Ports:
//   clk, reset         : clock, synchronous active-high reset (zeroes everything)
//   clear              : drop the entry; ctrl forced to 0, data zeroed only
//                        when CLEAR_DATA != 0 (otherwise data keeps stale value)
//   load               : capture loadCtrl/loadData and mark valid
//   valid, ctrl, data  : registered slot contents
// Priority: reset > clear > load.
module pipe_slot #(
  parameter int CTRL_W     = 4,
  parameter int DATA_W     = 75,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [CTRL_W-1:0] loadCtrl,
  input  logic [DATA_W-1:0] loadData,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLEAR_DATA != 0) begin
        data <= '0;
      end
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= loadCtrl;
      data  <= loadData;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Reusable pipeline stage register with a 2-entry skid buffer.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   flush               : kill both entries next edge; same-cycle input dropped
//   in_valid/in_ready   : upstream handshake; in_ready is a register output
//   in_ctrl, in_data    : upstream control / data bundles
//   out_valid/out_ready : downstream handshake (head entry)
//   out_ctrl, out_data  : head bundles; out_ctrl is zero whenever out_valid=0
//   occupancy           : entries held (0..2), doubles as the FSM state
//   stall_cycles        : saturating count of cycles with out_valid & !out_ready
//
// Handshake: a beat moves on a rising edge where valid and ready are both 1
// (accept = in_valid & in_ready, pop = out_valid & out_ready). A producer must
// hold valid and its bundles stable until that edge; ready never depends
// combinationally on valid, so no ready path crosses the stage.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W      = 4,
  parameter int DATA_W      = 75,
  parameter int CLEAR_DATA  = 0,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  occ_t occState, occNext;

  logic              mainValid, skidValid;
  logic [CTRL_W-1:0] mainCtrl, skidCtrl;
  logic [DATA_W-1:0] mainData, skidData;

  logic              mainLoad, mainClear, mainFromSkid;
  logic              skidLoad, skidClear;
  logic [CTRL_W-1:0] mainLoadCtrl;
  logic [DATA_W-1:0] mainLoadData;

  logic accept, pop;

  // The skid slot only fills when the stage already holds one beat, so its
  // registered valid is exactly "cannot take another beat".
  assign in_ready = !skidValid;
  assign accept   = in_valid & in_ready;
  assign pop      = mainValid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      occState <= OCC_EMPTY;
    end else begin
      occState <= occNext;
    end
  end

  always_comb begin
    occNext      = occState;
    mainLoad     = 1'b0;
    mainClear    = 1'b0;
    mainFromSkid = 1'b0;
    skidLoad     = 1'b0;
    skidClear    = 1'b0;
    if (flush) begin
      // A pop in this cycle is still taken by downstream; any accept is lost.
      mainClear = 1'b1;
      skidClear = 1'b1;
      occNext   = OCC_EMPTY;
    end else begin
      unique case (occState)
        OCC_EMPTY: begin
          if (accept) begin
            mainLoad = 1'b1;
            occNext  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && pop) begin
            mainLoad = 1'b1;
          end else if (pop) begin
            mainClear = 1'b1;
            occNext   = OCC_EMPTY;
          end else if (accept) begin
            skidLoad = 1'b1;
            occNext  = OCC_TWO;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            mainLoad     = 1'b1;
            mainFromSkid = 1'b1;
            skidClear    = 1'b1;
            occNext      = OCC_ONE;
          end
        end
        default: begin
          mainClear = 1'b1;
          skidClear = 1'b1;
          occNext   = OCC_EMPTY;
        end
      endcase
    end
  end

  assign mainLoadCtrl = mainFromSkid ? skidCtrl : in_ctrl;
  assign mainLoadData = mainFromSkid ? skidData : in_data;

  pipe_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .CLEAR_DATA (CLEAR_DATA)
  ) mainSlot (
    .clk      (clk),
    .reset    (reset),
    .clear    (mainClear),
    .load     (mainLoad),
    .loadCtrl (mainLoadCtrl),
    .loadData (mainLoadData),
    .valid    (mainValid),
    .ctrl     (mainCtrl),
    .data     (mainData)
  );

  pipe_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .CLEAR_DATA (CLEAR_DATA)
  ) skidSlot (
    .clk      (clk),
    .reset    (reset),
    .clear    (skidClear),
    .load     (skidLoad),
    .loadCtrl (in_ctrl),
    .loadData (in_data),
    .valid    (skidValid),
    .ctrl     (skidCtrl),
    .data     (skidData)
  );

  // Belt and braces: even a stale ctrl value can never leak out as a bubble.
  assign out_valid = mainValid;
  assign out_ctrl  = mainCtrl & {CTRL_W{mainValid}};
  assign out_data  = mainData;
  assign occupancy = occState;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (mainValid && !out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;

  localparam int CTRL_W      = 4;
  localparam int DATA_W      = 16;
  localparam int CLEAR_DATA  = 1;
  localparam int STALL_CNT_W = 3;

  logic                   clk;
  logic                   reset;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [CTRL_W-1:0]      in_ctrl;
  logic [DATA_W-1:0]      in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CTRL_W-1:0]      out_ctrl;
  logic [DATA_W-1:0]      out_data;
  logic [1:0]             occupancy;
  logic [STALL_CNT_W-1:0] stall_cycles;

  int n_checks;
  int n_pass;

  logic [DATA_W-1:0] exp_q[$];

  pipe_stage_skid_reg #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .CLEAR_DATA  (CLEAR_DATA),
    .STALL_CNT_W (STALL_CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge and let outputs settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_ctrl"},  32'(out_ctrl),  32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] exp_d;
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0);

    // reset then idle
    tick();
    tick();
    check_idle("reset");
    check("reset_out_data", 32'(out_data),     32'd0);
    check("reset_stall",    32'(stall_cycles), 32'd0);
    reset = 1'b0;

    // streaming: each beat visible one edge after it is accepted
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'b0011, DATA_W'(16'h10 + i));
      exp_q.push_back(DATA_W'(16'h10 + i));
      tick();
      exp_d = exp_q.pop_front();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data",  32'(out_data),  32'(exp_d));
      check("stream_ctrl",  32'(out_ctrl),  32'h3);
      check("stream_ready", 32'(in_ready),  32'd1);
    end
    drive(1'b0, '0, '0);
    tick();
    check("stream_drain_valid", 32'(out_valid),    32'd0);
    check("stream_drain_occ",   32'(occupancy),    32'd0);
    check("stream_stall",       32'(stall_cycles), 32'd0);

    // backpressure fill: A, B accepted, C held upstream until room
    out_ready = 1'b0;
    drive(1'b1, 4'b0101, 16'h1);
    tick();
    check("bp_a_occ",   32'(occupancy), 32'd1);
    check("bp_a_ready", 32'(in_ready),  32'd1);
    drive(1'b1, 4'b0101, 16'h2);
    tick();
    check("bp_b_occ",   32'(occupancy), 32'd2);
    check("bp_b_ready", 32'(in_ready),  32'd0);
    drive(1'b1, 4'b0101, 16'h3);
    tick();
    check("bp_c_occ",   32'(occupancy), 32'd2);
    check("bp_c_head",  32'(out_data),  32'h1);
    tick();
    tick();
    tick();
    check("bp_stall5",  32'(stall_cycles), 32'd5);
    check("bp_head_a",  32'(out_data),     32'h1);
    check("bp_ctrl_a",  32'(out_ctrl),     32'h5);
    out_ready = 1'b1;
    tick();
    check("bp_head_b",  32'(out_data),  32'h2);
    check("bp_occ_b",   32'(occupancy), 32'd1);
    tick();
    check("bp_head_c",  32'(out_data),  32'h3);
    check("bp_occ_c",   32'(occupancy), 32'd1);
    drive(1'b0, '0, '0);
    tick();
    check("bp_drain_valid", 32'(out_valid),    32'd0);
    check("bp_stall_hold",  32'(stall_cycles), 32'd5);

    // flush with full buffer; 0x55 must never appear
    out_ready = 1'b0;
    drive(1'b1, 4'b1111, 16'h21);
    tick();
    drive(1'b1, 4'b1111, 16'h22);
    tick();
    check("fl_full_occ", 32'(occupancy),    32'd2);
    check("fl_stall6",   32'(stall_cycles), 32'd6);
    flush = 1'b1;
    drive(1'b1, 4'b1111, 16'h55);
    tick();
    check_idle("flush_full");
    check("flush_full_data",  32'(out_data),     32'd0);
    check("flush_full_stall", 32'(stall_cycles), 32'd7);
    flush = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    check("flush_after_valid", 32'(out_valid), 32'd0);

    // flush in ONE with a same-cycle accept: the accept is dropped
    drive(1'b1, 4'b0011, 16'h66);
    tick();
    check("fl1_occ",  32'(occupancy), 32'd1);
    flush = 1'b1;
    drive(1'b1, 4'b0011, 16'h77);
    tick();
    check_idle("flush_one");
    check("flush_one_sat", 32'(stall_cycles), 32'd7);
    flush = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    check("flush_one_after", 32'(out_valid), 32'd0);

    // simultaneous accept + pop in ONE
    drive(1'b1, 4'b0001, 16'hA);
    tick();
    check("ap_head_a", 32'(out_data), 32'hA);
    out_ready = 1'b1;
    drive(1'b1, 4'b0010, 16'hB);
    tick();
    check("ap_head_b", 32'(out_data),  32'hB);
    check("ap_ctrl_b", 32'(out_ctrl),  32'h2);
    check("ap_occ",    32'(occupancy), 32'd1);
    check("ap_ready",  32'(in_ready),  32'd1);
    drive(1'b0, '0, '0);
    tick();
    check("ap_drain_occ", 32'(occupancy), 32'd0);

    // reset while full
    out_ready = 1'b0;
    drive(1'b1, 4'b1010, 16'hC1);
    tick();
    drive(1'b1, 4'b1010, 16'hC2);
    tick();
    check("rst_full_occ", 32'(occupancy), 32'd2);
    reset = 1'b1;
    drive(1'b1, 4'b1010, 16'hC3);
    tick();
    check_idle("rst_mid");
    check("rst_mid_data",  32'(out_data),     32'd0);
    check("rst_mid_stall", 32'(stall_cycles), 32'd0);
    reset = 1'b0;
    drive(1'b0, '0, '0);

    // stall counter saturation at 7 for a 3-bit counter
    drive(1'b1, 4'b0001, 16'hD0);
    tick();
    drive(1'b0, '0, '0);
    check("sat_start", 32'(stall_cycles), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("sat_count", 32'(stall_cycles), (i > 7) ? 32'd7 : 32'(i));
    end
    check("sat_head", 32'(out_data), 32'hD0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised pipeline stage register that generalises the fixed per-stage registers (IF/ID … MEM/WB) into one reusable block.
- Carries a control bundle and a data bundle of configurable width.
- Adds a valid/ready handshake with a 2-entry skid buffer, so backpressure does not need a combinational ready path.
- Adds synchronous flush (bubble insertion) and a stall-cycle counter; sits between any two pipeline stages.

Parameters:
- CTRL_W, 4: width of the control bundle (RegWrite, MemRead, Jtype, …); forced to 0 on every bubble.
- DATA_W, 75: width of the data bundle (e.g. 32 DataMemOut + 32 ALUOut + 6 ALUSelect + 5 WriteAddress).
- CLEAR_DATA, 0: 1 = data bundle also zeroed on flush/reset-of-entry; 0 = data bundle keeps its stale value (saves resets).
- STALL_CNT_W, 16: width of the saturating stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous kill of all held entries; the same-cycle input is dropped.
- in_valid  input  1  upstream has a beat.
- in_ready  output  1  registered; stage can accept a beat.
- in_ctrl  input  CTRL_W  upstream control bundle.
- in_data  input  DATA_W  upstream data bundle.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head this cycle.
- out_ctrl  output  CTRL_W  head control; all-zero whenever out_valid=0.
- out_data  output  DATA_W  head data.
- occupancy  output  2  entries held (0..2).
- stall_cycles  output  STALL_CNT_W  count of cycles with out_valid=1 and out_ready=0; saturates.

Behaviour:
- Interface decisions:
  - One clock, clk.
  - reset is synchronous and active-high.
  - All state changes occur on the rising edge of clk.
- Storage:
  - main slot (drives outputs) and skid slot; each slot holds valid, ctrl and data.
  - in_ready = !skid.valid, taken from a register; there is no combinational in→out path.
- Transfer definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- State is encoded by occupancy. Transitions below assume no flush:
  - EMPTY (0):
    - accept → ONE; main loads input.
    - out_valid=0, so pop cannot occur.
  - ONE (1):
    - accept & pop → ONE; main loads input.
    - pop only → EMPTY.
    - accept only → TWO; skid loads input.
    - neither → hold.
  - TWO (2):
    - in_ready=0, so accept cannot occur.
    - pop → ONE; main loads skid, skid clears.
    - no pop → hold.
- Latency and ordering:
  - Latency is 1 cycle from accept in EMPTY or ONE-with-pop to out_valid.
  - Strict FIFO order.
  - Full throughput of 1 beat/cycle when out_ready is held high.
- flush (priority over everything except reset):
  - Next cycle: both valids = 0 and both ctrl = 0.
  - Data zeroed only if CLEAR_DATA=1.
  - occupancy = 0 and in_ready = 1.
  - A same-cycle accept is discarded. A same-cycle pop is still considered consumed by downstream; downstream owns that decision.
- reset, next edge:
  - Valids and ctrl = 0; data = 0 (regardless of CLEAR_DATA).
  - occupancy = 0, in_ready = 1, stall_cycles = 0.
  - Reset mid-transfer discards everything.
  - While reset is high, outputs hold their reset values from the first reset edge onward.
- out_ctrl gating: out_ctrl = main.ctrl & {CTRL_W{main.valid}}. A bubble must never assert RegWrite/MemRead.
- stall_cycles:
  - +1 on each cycle with out_valid & !out_ready.
  - Saturates at all-ones.
  - Cleared only by reset; not cleared by flush.
- Width rules: ctrl and data are passed bit-exact; no sign or zero extension inside the block.

Decomposition:
- Shared package pipe_pkg:
  - occupancy encodings OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2.
  - Control-bit index constants (CTRL_REGWRITE=0, CTRL_MEMREAD=1, CTRL_JTYPE=2, CTRL_MEMWRITE=3) shared by all stage instances.
  - Default widths per stage (MEMWB_DATA_W=75, EXMEM_DATA_W, …).
- One sub-module, pipe_slot: a single valid+ctrl+data register with load, clear and CLEAR_DATA handling. It is instantiated twice (main, skid).

Test Plan:
- Reset then idle: reset=1 for 2 cycles → out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0, stall_cycles=0.
- Streaming: out_ready=1, 8 beats with data=0x10..0x17 and ctrl=4'b0011 on consecutive cycles → same beats appear 1 cycle later, one per cycle, in order; in_ready stays 1.
- Backpressure fill:
  - Stimulus: out_ready=0, push beats A=0x1, B=0x2, C=0x3 on consecutive cycles.
  - Cycle after B: occupancy=2, in_ready=0; C not accepted.
  - After 5 blocked cycles: stall_cycles=5.
  - Then raise out_ready: A, B, C emerge on successive cycles.
- Flush with full buffer: occupancy=2, assert flush with in_valid=1 data=0x55 → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; 0x55 never appears. With CLEAR_DATA=1, out_data=0.
- Simultaneous accept+pop in ONE: main=0xA, in=0xB, out_ready=1 → next cycle out_data=0xB, occupancy=1, skid unused.
- Reset mid-operation and saturation:
  - Reset while occupancy=2 → all outputs at reset values next cycle.
  - With STALL_CNT_W=3, hold a stall for 10 cycles → stall_cycles=7, no wrap.
